// File: rtl/extend_pipe_pkg.sv
// Shared opcode constants, extension modes and opcode decode for the
// immediate / load-alignment extension pipeline.
package extend_pipe_pkg;

  localparam logic [5:0] OPCODE_REGIMM = 6'h01;
  localparam logic [5:0] OPCODE_BEQ    = 6'h04;
  localparam logic [5:0] OPCODE_BNE    = 6'h05;
  localparam logic [5:0] OPCODE_BLEZ   = 6'h06;
  localparam logic [5:0] OPCODE_BGTZ   = 6'h07;
  localparam logic [5:0] OPCODE_ADDIU  = 6'h09;
  localparam logic [5:0] OPCODE_SLTI   = 6'h0A;
  localparam logic [5:0] OPCODE_SLTIU  = 6'h0B;
  localparam logic [5:0] OPCODE_ANDI   = 6'h0C;
  localparam logic [5:0] OPCODE_ORI    = 6'h0D;
  localparam logic [5:0] OPCODE_XORI   = 6'h0E;
  localparam logic [5:0] OPCODE_LUI    = 6'h0F;
  localparam logic [5:0] OPCODE_LB     = 6'h20;
  localparam logic [5:0] OPCODE_LH     = 6'h21;
  localparam logic [5:0] OPCODE_LWL    = 6'h22;
  localparam logic [5:0] OPCODE_LW     = 6'h23;
  localparam logic [5:0] OPCODE_LBU    = 6'h24;
  localparam logic [5:0] OPCODE_LHU    = 6'h25;
  localparam logic [5:0] OPCODE_LWR    = 6'h26;
  localparam logic [5:0] OPCODE_SW     = 6'h2B;

  typedef enum logic [2:0] {
    IMM_S, IMM_Z, LUI, BYTE, HALF, WORD, LWL, LWR
  } ext_mode_t;

  typedef struct packed {
    ext_mode_t mode;
    logic      sgn;   // sign-extend the loaded lane (BYTE/HALF only)
  } decode_t;

  function automatic decode_t decode_op(input logic [5:0] opcode);
    decode_t d;
    d.mode = IMM_Z;
    d.sgn  = 1'b1;
    case (opcode)
      OPCODE_SW, OPCODE_ADDIU, OPCODE_SLTI, OPCODE_SLTIU, OPCODE_BEQ,
      OPCODE_BNE, OPCODE_BGTZ, OPCODE_BLEZ, OPCODE_REGIMM: d.mode = IMM_S;
      OPCODE_ANDI, OPCODE_ORI, OPCODE_XORI:                 d.mode = IMM_Z;
      OPCODE_LUI:                                           d.mode = LUI;
      OPCODE_LB:  d.mode = BYTE;
      OPCODE_LBU: begin d.mode = BYTE; d.sgn = 1'b0; end
      OPCODE_LH:  d.mode = HALF;
      OPCODE_LHU: begin d.mode = HALF; d.sgn = 1'b0; end
      OPCODE_LW:  d.mode = WORD;
      OPCODE_LWL: d.mode = LWL;
      OPCODE_LWR: d.mode = LWR;
      default:    d.mode = IMM_Z;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/extend_pipe_if.sv
// Request/response bundle for extend_pipe; master is the producer/consumer side.
interface extend_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [1:0]        byte_offset;
  logic [IMM_W-1:0]  imm;
  logic [31:0]       mem_word;
  logic [31:0]       rt_old;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output flush, in_valid, opcode, byte_offset, imm, mem_word, rt_old, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  flush, in_valid, opcode, byte_offset, imm, mem_word, rt_old, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/extend_pipe_load_align.sv
// Combinational load lane selection and LWL/LWR merge into a 32-bit word,
// flagging misaligned LW/LH/LHU.
module load_align
  import extend_pipe_pkg::*;
(
  input  ext_mode_t   mode,
  input  logic        sgn,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] rt_old,
  output logic [31:0] word,
  output logic        err
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = 8'(mem_word >> {byte_offset, 3'b000});
  assign half_lane = byte_offset[1] ? mem_word[31:16] : mem_word[15:0];

  // NOTE: every output gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    word = '0;
    err  = 1'b0;
    case (mode)
      BYTE: word = {{24{sgn & byte_lane[7]}}, byte_lane};
      HALF: begin
        if (byte_offset[0]) err  = 1'b1;
        else                word = {{16{sgn & half_lane[15]}}, half_lane};
      end
      WORD: begin
        if (byte_offset != 2'd0) err  = 1'b1;
        else                     word = mem_word;
      end
      LWL: begin
        case (byte_offset)
          2'd0:    word = {mem_word[7:0],  rt_old[23:0]};
          2'd1:    word = {mem_word[15:0], rt_old[15:0]};
          2'd2:    word = {mem_word[23:0], rt_old[7:0]};
          default: word = mem_word;
        endcase
      end
      LWR: begin
        case (byte_offset)
          2'd0:    word = mem_word;
          2'd1:    word = {rt_old[31:24], mem_word[31:8]};
          2'd2:    word = {rt_old[31:16], mem_word[31:16]};
          default: word = {rt_old[31:8],  mem_word[31:24]};
        endcase
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/extend_pipe.sv
// One-stage extension pipeline: decodes the opcode, widens the immediate or
// aligned load word to DATA_W and holds it in a valid/ready output register.
module extend_pipe
  import extend_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic clk,
  input  logic reset_n,
  extend_pipe_if.slave bus
);

  decode_t           dec;
  logic [31:0]       align_word;
  logic              align_err;
  logic [DATA_W-1:0] result;
  logic              accept;

  assign dec = decode_op(bus.opcode);

  load_align u_align (
    .mode        (dec.mode),
    .sgn         (dec.sgn),
    .byte_offset (bus.byte_offset),
    .mem_word    (bus.mem_word),
    .rt_old      (bus.rt_old),
    .word        (align_word),
    .err         (align_err)
  );

  // Load words are already extended to 32 bits inside load_align, so a
  // plain sign-extension of bit 31 is correct for signed and unsigned loads.
  always_comb begin
    result = '0;
    case (dec.mode)
      IMM_S:   result = DATA_W'($signed(bus.imm));
      IMM_Z:   result = DATA_W'(bus.imm);
      LUI:     result = DATA_W'($signed({bus.imm, {IMM_W{1'b0}}}));
      default: result = align_err ? '0 : DATA_W'($signed(align_word));
    endcase
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments only; the data and
  // error registers are reset as well because reset must clear them at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      if (bus.flush)         bus.out_valid <= 1'b0;
      else if (accept)       bus.out_valid <= 1'b1;
      else if (bus.out_ready) bus.out_valid <= 1'b0;

      if (accept) begin
        bus.out_data <= result;
        bus.out_err  <= (dec.mode == HALF || dec.mode == WORD) && align_err;
      end
    end
  end

endmodule
